// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module   : dmem_pkg
//  Brief    : Shared FSM encoding and default parameters for dmem_responder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam int c_ADDR_W     = 12;
    localparam int c_DATA_W     = 32;
    localparam int c_DEPTH_LOG2 = 12;
    localparam int c_LATENCY    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
//  Module   : dmem_array
//  Brief    : Word storage, synchronous write port, combinational read port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] r_mem [2**DEPTH_LOG2];

    // No reset: contents must survive a responder reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Fixed-latency single-outstanding data-memory responder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = c_ADDR_W,
    parameter int DATA_W     = c_DATA_W,
    parameter int DEPTH_LOG2 = c_DEPTH_LOG2,
    parameter int LATENCY    = c_LATENCY
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_wren,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    input  logic              resp_ready
);

    localparam int c_CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_wren;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_data;
    logic [DATA_W-1:0]    r_resp_data;
    logic                 r_resp_err;
    logic [DATA_W-1:0]    w_rd_data;
    logic                 w_oor;
    logic                 w_accept;
    logic                 w_access;
    logic                 w_mem_we;

    // Upper address bits are range-checked rather than dropped, so nothing aliases.
    generate
        if (DEPTH_LOG2 < ADDR_W) begin : g_range_chk
            assign w_oor = |r_addr[ADDR_W-1:DEPTH_LOG2];
        end else begin : g_range_full
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_access = (r_state == ST_WAIT) && (r_cnt == '0);
    assign w_mem_we = w_access && r_wren && !w_oor;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = c_CNT_W'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wren <= req_wren;
                r_addr <= req_addr;
                r_data <= req_data;
            end
            if (w_access) begin
                r_resp_data <= (!r_wren && !w_oor) ? w_rd_data : '0;
                r_resp_err  <= w_oor;
            end
        end
    end

    assign resp_data = resp_valid ? r_resp_data : '0;
    assign resp_err  = resp_valid & r_resp_err;

    dmem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock   (clock),
        .wr_en   (w_mem_we),
        .wr_addr (r_addr[DEPTH_LOG2-1:0]),
        .wr_data (r_data),
        .rd_addr (r_addr[DEPTH_LOG2-1:0]),
        .rd_data (w_rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Directed scoreboard bench for dmem_responder (DEPTH_LOG2=8).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    localparam int c_ADDR_W  = 12;
    localparam int c_DATA_W  = 32;
    localparam int c_DLOG2   = 8;
    localparam int c_LAT     = 2;
    localparam int c_BOUND   = 50;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_wren = 1'b0;
    logic [c_ADDR_W-1:0] req_addr = '0;
    logic [c_DATA_W-1:0] req_data = '0;
    logic                req_ready;
    logic                resp_valid;
    logic [c_DATA_W-1:0] resp_data;
    logic                resp_err;
    logic                resp_ready = 1'b1;

    dmem_responder #(
        .ADDR_W     (c_ADDR_W),
        .DATA_W     (c_DATA_W),
        .DEPTH_LOG2 (c_DLOG2),
        .LATENCY    (c_LAT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_wren   (req_wren),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_ready (resp_ready)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic                wren;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
        logic [c_DATA_W-1:0] exp_data;
        logic                exp_err;
    } txn_t;

    txn_t                q[$];
    logic [c_DATA_W-1:0] model [2**c_DLOG2];
    int  n_asserts = 0;
    int  n_fail    = 0;
    int  acc_edge  = 0;
    bit  seen_resp = 1'b1;
    bit  acc_now;
    bit  resp_now;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample just after the falling edge, then advance to the next falling edge.
    task automatic step();
        txn_t t;
        txn_t e;
        bit   oor;
        #1;
        acc_now  = 1'b0;
        resp_now = 1'b0;
        if (req_valid && req_ready) begin
            oor        = (req_addr >= c_ADDR_W'(2**c_DLOG2));
            e.wren     = req_wren;
            e.addr     = req_addr;
            e.wdata    = req_data;
            e.exp_err  = oor;
            e.exp_data = (req_wren || oor) ? '0 : model[req_addr[c_DLOG2-1:0]];
            q.push_back(e);
            acc_edge  = cyc + 1;
            seen_resp = 1'b0;
            acc_now   = 1'b1;
        end
        if (resp_valid && !seen_resp) begin
            check("latency", 32'(cyc - acc_edge + 1), 32'(c_LAT + 1));
            seen_resp = 1'b1;
        end
        if (resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                t = q.pop_front();
                check("resp_data", resp_data, t.exp_data);
                check("resp_err", 32'(resp_err), 32'(t.exp_err));
                if (t.wren && !t.exp_err) model[t.addr[c_DLOG2-1:0]] = t.wdata;
            end
            resp_now = 1'b1;
        end
        @(negedge clock);
    endtask

    task automatic do_txn(input logic wren, input logic [c_ADDR_W-1:0] addr,
                          input logic [c_DATA_W-1:0] data);
        int n;
        req_valid = 1'b1;
        req_wren  = wren;
        req_addr  = addr;
        req_data  = data;
        n = 0;
        do begin step(); n++; end while (!acc_now && n < c_BOUND);
        if (!acc_now) check("accept_timeout", 32'd1, 32'd0);
        req_valid = 1'b0;
        n = 0;
        do begin step(); n++; end while (!resp_now && n < c_BOUND);
        if (!resp_now) check("resp_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int edges[4];
        int k;
        logic [c_ADDR_W-1:0] prev_addr;

        // Reset state, with clock running under reset.
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clock);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b0;

        // Known contents for later loads.
        do_txn(1'b1, 12'h000, 32'h1111_0000);
        do_txn(1'b1, 12'h001, 32'h2222_0001);
        do_txn(1'b1, 12'h002, 32'h3333_0002);
        do_txn(1'b1, 12'h003, 32'h4444_0003);
        do_txn(1'b1, 12'h020, 32'h5555_0020);

        // Store then load.
        do_txn(1'b1, 12'h010, 32'hDEAD_BEEF);
        do_txn(1'b0, 12'h010, 32'h0);
        check("model_010", model[8'h10], 32'hDEAD_BEEF);

        // Backpressure on a load of 0x010.
        resp_ready = 1'b0;
        req_valid = 1'b1; req_wren = 1'b0; req_addr = 12'h010; req_data = '0;
        n = 0;
        do begin step(); n++; end while (!acc_now && n < c_BOUND);
        req_valid = 1'b1;
        n = 0;
        while (!resp_valid && n < c_BOUND) begin step(); n++; end
        if (!resp_valid) check("bp_timeout", 32'd1, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_data", resp_data, 32'hDEAD_BEEF);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            step();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        n = 0;
        do begin step(); n++; end while (!resp_now && n < c_BOUND);
        if (!resp_now) check("bp_release_timeout", 32'd1, 32'd0);

        // Out-of-range accesses.
        do_txn(1'b1, 12'h100, 32'h1234_5678);
        do_txn(1'b0, 12'h100, 32'h0);
        do_txn(1'b0, 12'h000, 32'h0);
        check("oor_no_alias", model[8'h00], 32'h1111_0000);

        // Reset during WAIT of a store.
        req_valid = 1'b1; req_wren = 1'b1; req_addr = 12'h020; req_data = 32'hA5A5_A5A5;
        n = 0;
        do begin step(); n++; end while (!acc_now && n < c_BOUND);
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_resp_data", resp_data, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        seen_resp = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("abort_no_resp", 32'(resp_valid), 32'd0);
            step();
        end
        do_txn(1'b0, 12'h020, 32'h0);
        check("abort_model_020", model[8'h20], 32'h5555_0020);

        // Streaming loads with req_valid held high.
        req_valid = 1'b1; req_wren = 1'b0; req_addr = 12'h000;
        k = 0;
        n = 0;
        while (k < 4 && n < 4 * c_BOUND) begin
            prev_addr = req_addr;
            step();
            n++;
            if (acc_now) begin
                check("stream_addr", 32'(prev_addr), 32'(k));
                edges[k] = acc_edge;
                k++;
                req_addr = c_ADDR_W'(k);
            end
        end
        req_valid = 1'b0;
        if (k < 4) check("stream_timeout", 32'(k), 32'd4);
        n = 0;
        while (q.size() > 0 && n < c_BOUND) begin step(); n++; end
        check("stream_drained", 32'(q.size()), 32'd0);
        for (int i = 1; i < 4; i++) begin
            if (i < k) check("stream_spacing", 32'(edges[i] - edges[0]), 32'(4 * i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
